apb_slave_regbank: RTL
======================

// Module: apb_slave_regbank
// PURPOSE
//  Parametrised APB4 completer: a bank of NUM_REGS word registers with byte strobes,
//  configurable wait states and PSLVERR signalling. Sits behind the APB bridge as the
//  generic control/status slave. Exports its RW contents to the fabric and returns
//  hardware status words for read-only slots.
// PARAMETERS
//  ADDR_W      8        PADDR width; requires NUM_REGS*(DATA_W/8) <= 2**ADDR_W
//  DATA_W      32       PWDATA/PRDATA width; multiple of 8; PSTRB width = DATA_W/8
//  NUM_REGS    16       number of word registers (>=1)
//  WAIT_STATES 0        PREADY-low cycles in each access phase (0..15)
//  RO_MASK     '0       bit i=1 -> register i is read-only, reads hw_in slice i
//  RESET_VAL   '0       reset value of every RW register
// PORTS
//  PCLK       in   1                  clock, all logic on rising edge
//  PRESET     in   1                  synchronous reset, active-high
//  PSELx      in   1                  slave select
//  PENABLE    in   1                  access phase
//  PWRITE     in   1                  1=write, 0=read
//  PADDR      in   ADDR_W             byte address
//  PWDATA     in   DATA_W             write data
//  PSTRB      in   DATA_W/8           write byte lanes
//  PRDATA     out  DATA_W             read data
//  PREADY     out  1                  transfer complete
//  PSLVERR    out  1                  error, valid only while PREADY=1
//  reg_out    out  NUM_REGS*DATA_W    flattened register contents (reg i at [i*DATA_W +: DATA_W])
//  hw_in      in   NUM_REGS*DATA_W    status words for RO slots (unused slices ignored)
// BEHAVIOUR
//  Reset (PRESET=1 at edge): state=IDLE, cnt=0, PRDATA=0, PREADY=0, PSLVERR=0,
//   RW regs=RESET_VAL. Reset mid-transfer aborts it; the pending write is discarded.
//  FSM states: IDLE, ACCESS.
//   IDLE: PSELx & !PENABLE (setup) -> ACCESS; load cnt=WAIT_STATES; register decode,
//    err flag and PRDATA (read: reg/hw_in word; write or err: 0). Otherwise stay.
//   ACCESS: PREADY = (cnt==0), combinational from flops. cnt>0 -> cnt--.
//    cnt==0 & PSELx & PENABLE -> transfer completes, commit write, -> IDLE.
//    PSELx=0 while in ACCESS (master abort) -> IDLE, no write, no error.
//  Latency: WAIT_STATES=0 -> 2-cycle APB transfer (setup + 1 access); else +WAIT_STATES.
//  Back-to-back: new setup in the cycle after completion is accepted from IDLE.
//  Decode: index = PADDR[ADDR_W-1:log2(DATA_W/8)]. err if index >= NUM_REGS,
//   PADDR low bits != 0 (misaligned), or PWRITE to an RO_MASK register.
//  PSLVERR = err & PREADY; 0 otherwise. Erroring write never modifies any register.
//  Write commit: byte lane b updated iff PSTRB[b]; PSTRB=0 is a legal no-op, no error.
//  Reads ignore PSTRB; read data is sampled at the setup edge and held stable until PREADY.
//  PRDATA returns to 0 the cycle after completion; reg_out updates the cycle after commit.
// STRUCTURE
//  apb_pkg: typedef enum logic {IDLE, ACCESS} apb_slv_state_e; function
//   apb_strb_merge(old, wdata, strb) for byte-lane merge; constant APB_MAX_WAIT=15.
//  Top module: FSM, wait counter, decode/err; sub-module apb_regbank_store
//   (NUM_REGS x DATA_W flops, strobed write port, read mux over RO_MASK/hw_in).
// TESTING
//  Reset: regs=0x0 after PRESET; read 0x04 -> PRDATA=0x0, PSLVERR=0, PREADY after 1 access cycle.
//  Write 0xDEADBEEF to 0x08, PSTRB=4'b0101, then read 0x08 -> 0x00AD00EF.
//  WAIT_STATES=3: PREADY low exactly 3 access cycles, high on the 4th; data committed then.
//  Out-of-range 0x40 (NUM_REGS=16) write/read -> PSLVERR=1 with PREADY, no reg change;
//   misaligned 0x05 -> PSLVERR=1.
//  RO_MASK bit2, hw_in[2]=0x12345678: read 0x08 -> 0x12345678; write -> PSLVERR=1.
//  PRESET asserted mid-wait on a write to 0x0C -> reg 3 stays 0, FSM IDLE, PREADY=0;
//   back-to-back writes 0x00/0x04 both commit.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, limits and byte-lane helper for the APB register bank
// Contents:
//   apb_slv_state_e  completer FSM state (IDLE, ACCESS)
//   APB_MAX_WAIT     largest supported WAIT_STATES value; sizes the wait counter
//   apb_strb_merge   one byte lane of a strobed write: new byte if strobe set, else old
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  localparam int APB_MAX_WAIT = 15;

  function automatic logic [7:0] apb_strb_merge(
    input logic [7:0] old_byte,
    input logic [7:0] wdata_byte,
    input logic       strb
  );
    return strb ? wdata_byte : old_byte;
  endfunction

endpackage

// File: rtl/apb_regbank_store.sv
// rtl/apb_regbank_store.sv - register storage with strobed write port and RO-aware read mux
// Ports:
//   clk, rst             clock, synchronous active-high reset (RW slots load RESET_VAL)
//   we, wr_idx           commit strobe and target register index
//   wdata, strb          write data and byte-lane enables
//   rd_idx, rd_data      combinational read port; RO slots return the hw_in word
//   reg_out              flattened flop contents, register i at [i*DATA_W +: DATA_W]
//   hw_in                status words, only slices flagged in RO_MASK are looked at
module apb_regbank_store
  import apb_pkg::*;
#(
  parameter int                    DATA_W    = 32,
  parameter int                    NUM_REGS  = 16,
  parameter int                    IDX_W     = 4,
  parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
  parameter logic [DATA_W-1:0]     RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        strb,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] hw_in
);

  localparam int STRB_W = DATA_W / 8;

  // Word each slot presents to the read mux.
  logic [NUM_REGS*DATA_W-1:0] slot_rd;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic [DATA_W-1:0] q;

    // RO slots are never written: the top flags any write to them as an error.
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= RESET_VAL;
      end else if (we && (wr_idx == IDX_W'(r))) begin
        for (int b = 0; b < STRB_W; b++) begin
          q[b*8 +: 8] <= apb_strb_merge(q[b*8 +: 8], wdata[b*8 +: 8], strb[b]);
        end
      end
    end

    assign reg_out[r*DATA_W +: DATA_W] = q;

    if (RO_MASK[r]) begin : g_ro
      assign slot_rd[r*DATA_W +: DATA_W] = hw_in[r*DATA_W +: DATA_W];
    end else begin : g_rw
      logic unused_hw;
      assign unused_hw = ^hw_in[r*DATA_W +: DATA_W];
      assign slot_rd[r*DATA_W +: DATA_W] = q;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_idx == IDX_W'(r)) rd_data = slot_rd[r*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - APB4 completer over a bank of word registers with wait states and PSLVERR
// Ports:
//   PCLK, PRESET         clock, synchronous active-high reset
//   PSELx, PENABLE       APB select and access-phase strobe
//   PWRITE, PADDR        direction and byte address
//   PWDATA, PSTRB        write data and byte-lane enables
//   PRDATA               read data, captured at setup, held until completion, then 0
//   PREADY, PSLVERR      completion and error (error only qualified by PREADY)
//   reg_out              flattened register contents
//   hw_in                status words returned for read-only slots
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int                  ADDR_W      = 8,
  parameter int                  DATA_W      = 32,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       PSELx,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic [DATA_W-1:0]          PWDATA,
  input  logic [DATA_W/8-1:0]        PSTRB,
  output logic [DATA_W-1:0]          PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] hw_in
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W  = $clog2(APB_MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);

  apb_slv_state_e    state;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  dec_idx;
  logic              in_range;
  logic              ro_hit;
  logic              dec_err;
  logic [DATA_W-1:0] rd_data;
  logic              commit;

  // Decode is evaluated from the live bus and only consumed at the setup edge.
  assign word_addr = PADDR >> LSB;
  assign dec_idx   = IDX_W'(word_addr);
  assign in_range  = 32'(word_addr) < NUM_REGS;

  always_comb begin
    ro_hit = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (dec_idx == IDX_W'(r)) ro_hit = RO_MASK[r];
    end
  end

  assign dec_err = !in_range || (|(PADDR & ALIGN_MASK)) || (PWRITE && ro_hit);

  assign PREADY  = (state == ACCESS) && (cnt == '0);
  assign PSLVERR = err_q && PREADY;
  assign commit  = PREADY && PSELx && PENABLE && wr_q && !err_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state  <= IDLE;
      cnt    <= '0;
      PRDATA <= '0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
      idx_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PSELx && !PENABLE) begin
            state  <= ACCESS;
            cnt    <= CNT_W'(WAIT_STATES);
            err_q  <= dec_err;
            wr_q   <= PWRITE;
            idx_q  <= dec_idx;
            PRDATA <= (PWRITE || dec_err) ? '0 : rd_data;
          end
        end
        ACCESS: begin
          if (!PSELx) begin
            // Requester dropped the transfer: no commit, no error response.
            state  <= IDLE;
            PRDATA <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (PENABLE) begin
            state  <= IDLE;
            PRDATA <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_regbank_store #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .RO_MASK   (RO_MASK),
    .RESET_VAL (RESET_VAL)
  ) u_store (
    .clk     (PCLK),
    .rst     (PRESET),
    .we      (commit),
    .wr_idx  (idx_q),
    .wdata   (PWDATA),
    .strb    (PSTRB),
    .rd_idx  (dec_idx),
    .rd_data (rd_data),
    .reg_out (reg_out),
    .hw_in   (hw_in)
  );

endmodule
